gpr_add_datapath: RTL and testbench

- Integer execute datapath slice: a general-purpose register file with two combinational read ports and one synchronous write port, plus a full-width adder.
- The adder forms rdata1 + imm; when enabled, the result is written back to rd on the next rising clock edge (addi-style execute).
- Sits inside the EXU of the single-cycle core, between decode (rs1/rs2/rd/imm/enable) and next-stage consumers of src1/src2/sum.

---
 rtl/gpr_add_datapath_pkg.sv | 21 ++
 rtl/gpr_regfile.sv | 59 +++++
 rtl/gpr_add_datapath.sv | 55 +++++
 tb/tb_gpr_add_datapath.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gpr_add_datapath_pkg.sv
// ---------------------------------------------------------------------------
// gpr_add_datapath_pkg
//   Shared constants and types for the integer execute slice (register file
//   plus addi-style adder).
//
//   GPR_ADDR_W : register index width (32 architectural registers)
//   XLEN       : register / immediate / adder width
//   REG_ZERO   : index of the hardwired-zero register
//   gpr_idx_t  : register index type
//   xlen_t     : machine word type
// ---------------------------------------------------------------------------
package gpr_add_datapath_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int XLEN       = 64;
  localparam int REG_ZERO   = 0;

  typedef logic [GPR_ADDR_W-1:0] gpr_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/gpr_regfile.sv
// ---------------------------------------------------------------------------
// gpr_regfile
//   General-purpose register file: 2**ADDR_WIDTH words of DATA_WIDTH bits,
//   two combinational read ports, one synchronous write port. Register 0
//   always reads as zero and ignores writes. Asynchronous active-low reset
//   clears every word.
//
//   clk     in  : system clock, writes on rising edge
//   rst_n   in  : asynchronous active-low reset
//   wdata   in  : write data
//   waddr   in  : write index
//   wen     in  : write enable
//   raddr1  in  : read index, port 1
//   raddr2  in  : read index, port 2
//   rdata1  out : contents of register raddr1
//   rdata2  out : contents of register raddr2
// ---------------------------------------------------------------------------
module gpr_regfile
  import gpr_add_datapath_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_W,
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Storage update. Reset clears the whole array immediately and wins over
  // any write presented in the same cycle. Writes aimed at register 0 are
  // dropped here so that its storage word stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wen && (waddr != ZERO_IDX)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports have no write bypass: a write in flight becomes visible only
  // after the clock edge. Index 0 is forced to zero on the read side too, so
  // the hardwired-zero rule never depends on the storage word.
  assign rdata1 = (raddr1 == ZERO_IDX) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == ZERO_IDX) ? '0 : regs[raddr2];

endmodule

// File: rtl/gpr_add_datapath.sv
// ---------------------------------------------------------------------------
// gpr_add_datapath
//   Execute slice: register file plus adder computing src1 + imm, written
//   back to rd on the next rising edge when wb_en is set (addi behaviour).
//
//   clk    in  : system clock
//   rst_n  in  : asynchronous active-low reset
//   rs1    in  : read index, port 1 (adder operand)
//   rs2    in  : read index, port 2 (observation only)
//   rd     in  : write-back index
//   imm    in  : sign-extended immediate
//   wb_en  in  : write-back enable
//   src1   out : contents of register rs1
//   src2   out : contents of register rs2
//   sum    out : src1 + imm, wrapping modulo 2**DATA_WIDTH
// ---------------------------------------------------------------------------
module gpr_add_datapath
  import gpr_add_datapath_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_W,
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  wb_en,
  output logic [DATA_WIDTH-1:0] src1,
  output logic [DATA_WIDTH-1:0] src2,
  output logic [DATA_WIDTH-1:0] sum
);

  gpr_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .wdata  (sum),
    .waddr  (rd),
    .wen    (wb_en),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (src1),
    .rdata2 (src2)
  );

  // Plain unsigned add with the carry discarded; two's complement makes the
  // same result correct for signed immediates. rd == rs1 is safe because the
  // write-back goes through the register edge, not back into this path.
  assign sum = src1 + imm;

endmodule

// File: tb/tb_gpr_add_datapath.sv
// ---------------------------------------------------------------------------
// tb_gpr_add_datapath
//   Directed, self-checking bench for gpr_add_datapath with hand-computed
//   expected values.
// ---------------------------------------------------------------------------
module tb_gpr_add_datapath;

  localparam int AW = 5;
  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rd;
  logic [DW-1:0] imm;
  logic          wb_en;
  logic [DW-1:0] src1;
  logic [DW-1:0] src2;
  logic [DW-1:0] sum;

  int checkCount;
  int errorCount;

  gpr_add_datapath #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs1   (rs1),
    .rs2   (rs2),
    .rd    (rd),
    .imm   (imm),
    .wb_en (wb_en),
    .src1  (src1),
    .src2  (src2),
    .sum   (sum)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the stimulus stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive all decode-side inputs, then let the combinational paths settle.
  task automatic applyStimulus(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                               input logic [AW-1:0] rdi, input logic [DW-1:0] im,
                               input logic we);
    rs1   = r1;
    rs2   = r2;
    rd    = rdi;
    imm   = im;
    wb_en = we;
    #1;
  endtask

  // Advance through one rising edge, resuming 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write value v into register r via x0 + imm.
  task automatic loadReg(input logic [AW-1:0] r, input logic [DW-1:0] v);
    applyStimulus('0, '0, r, v, 1'b1);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0);
  endtask

  // Directed sequence following the test plan.
  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b1;
    applyStimulus('0, '0, '0, '0, 1'b0);
    tick();
    tick();

    // Asynchronous reset in the middle of a cycle; no edge needed.
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(AW'(i), AW'(31 - i), '0, 64'h7, 1'b0);
      checkOutput($sformatf("reset_src1_x%0d", i), src1, 64'h0);
      checkOutput($sformatf("reset_src2_x%0d", 31 - i), src2, 64'h0);
    end
    checkOutput("reset_sum_is_imm", sum, 64'h7);

    // Writes are blocked while reset is held, even across an edge.
    applyStimulus(5'd0, 5'd1, 5'd1, 64'h7, 1'b1);
    tick();
    applyStimulus(5'd1, 5'd1, 5'd0, 64'h0, 1'b0);
    checkOutput("reset_blocks_write", src1, 64'h0);

    // Release between edges.
    #2;
    rst_n = 1'b1;
    tick();

    // Load immediate into x1.
    applyStimulus(5'd0, 5'd0, 5'd1, 64'd5, 1'b1);
    checkOutput("li_sum_before_edge", sum, 64'd5);
    tick();
    applyStimulus(5'd1, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    checkOutput("li_src1", src1, 64'd5);
    checkOutput("li_src2", src2, 64'd5);
    checkOutput("li_sum_minus3", sum, 64'd2);

    // Wrap-around: x2 = all ones, x3 preloaded then overwritten with 0.
    loadReg(5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    loadReg(5'd3, 64'h55);
    applyStimulus(5'd3, 5'd2, 5'd0, 64'h0, 1'b0);
    checkOutput("preload_x3", src1, 64'h55);
    checkOutput("ones_x2", src2, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(5'd2, 5'd3, 5'd3, 64'd1, 1'b1);
    checkOutput("wrap_sum", sum, 64'h0);
    tick();
    applyStimulus(5'd3, 5'd2, 5'd0, 64'd9, 1'b0);
    checkOutput("wrap_x3", src1, 64'h0);
    checkOutput("wrap_sum_x3_plus9", sum, 64'd9);

    // x0 protection.
    applyStimulus(5'd0, 5'd0, 5'd0, 64'h1234, 1'b1);
    checkOutput("x0_sum", sum, 64'h1234);
    tick();
    applyStimulus(5'd0, 5'd0, 5'd0, 64'h0, 1'b0);
    checkOutput("x0_src1_zero", src1, 64'h0);
    checkOutput("x0_src2_zero", src2, 64'h0);

    // wb_en low leaves x4 untouched.
    loadReg(5'd4, 64'hABCD);
    applyStimulus(5'd0, 5'd0, 5'd4, 64'h999, 1'b0);
    tick();
    applyStimulus(5'd4, 5'd0, 5'd0, 64'h0, 1'b0);
    checkOutput("no_wen_x4", src1, 64'hABCD);

    // Accumulate in x5 with rs1 == rd; rs2 observes x1 and must not affect sum.
    loadReg(5'd5, 64'd10);
    applyStimulus(5'd5, 5'd1, 5'd5, 64'd1, 1'b1);
    checkOutput("acc_src1_before", src1, 64'd10);
    checkOutput("acc_sum_before", sum, 64'd11);
    checkOutput("acc_src2_x1", src2, 64'd5);
    tick();
    checkOutput("acc_src1_edge1", src1, 64'd11);
    tick();
    checkOutput("acc_src1_edge2", src1, 64'd12);
    tick();
    checkOutput("acc_src1_edge3", src1, 64'd13);
    checkOutput("acc_sum_edge3", sum, 64'd14);

    // Reset mid-accumulation: contents vanish without waiting for an edge.
    tick();
    checkOutput("acc_src1_edge4", src1, 64'd14);
    #3;
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_src1", src1, 64'h0);
    checkOutput("midrst_src2", src2, 64'h0);
    checkOutput("midrst_sum", sum, 64'd1);
    tick();
    checkOutput("midrst_held_src1", src1, 64'h0);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("release_before_edge", src1, 64'h0);
    tick();
    checkOutput("release_first_write", src1, 64'd1);
    checkOutput("release_x1_cleared", src2, 64'h0);
    tick();
    checkOutput("release_second_write", src1, 64'd2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
